onchip_mem_test_master: RTL



---
 rtl/onchip_mem_test_master.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/onchip_mem_test_master.sv
// onchip_mem_test_master
//   Avalon-MM master that writes a pattern over a word region of the on-chip
//   RAM, reads the region back and checks every returned word against the
//   regenerated pattern. Intended as a built-in self-test / bring-up engine.
//
// Ports
//   clk, reset_n          : clock, asynchronous active-low reset
//   start                 : one-cycle run request, sampled only when idle
//   base_addr, length     : region start word and word count (clamped to 2^ADDR_W)
//   seed, pattern_mode    : pattern seed; 0 = incrementing, 1 = Galois LFSR
//   busy, done, pass      : run in progress, completion pulse, last-run verdict
//   err_count             : mismatches seen in the last run
//   first_err_addr        : address of the first mismatch (0 if none)
//   avm_*                 : Avalon-MM master to the RAM s1 slave (fixed latency)
module onchip_mem_test_master #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     length,
  input  logic [DATA_W-1:0]   seed,
  input  logic                pattern_mode,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ADDR_W:0]     err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [ADDR_W-1:0]   avm_address,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_chipselect,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic [DATA_W-1:0]   avm_readdata
);

  localparam logic [ADDR_W:0]   MAX_LEN   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   RL_LAST   = (ADDR_W+1)'(READ_LATENCY - 1);
  localparam logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(16'hB400);
  localparam logic [DATA_W-1:0] LFSR_ONE  = DATA_W'(1);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] l);
    return (l > MAX_LEN) ? MAX_LEN : l;
  endfunction

  function automatic logic [DATA_W-1:0] next_pat(input logic [DATA_W-1:0] p,
                                                 input logic lfsr);
    if (lfsr) return (p >> 1) ^ (p[0] ? LFSR_TAPS : '0);
    else      return p + 1'b1;
  endfunction

  state_t              state, state_d;
  logic [ADDR_W:0]     idx, idx_d;
  logic [ADDR_W:0]     len_r;
  logic                mode_r;
  logic [ADDR_W-1:0]   base_r;
  logic [DATA_W-1:0]   seed_r;
  logic [DATA_W-1:0]   pat, pat_d;
  logic                err_found, found_d;

  logic                cs_d, we_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic                busy_d, done_d, pass_d;
  logic [ADDR_W:0]     err_d;
  logic [ADDR_W-1:0]   first_d;
  logic                start_acc;

  logic [ADDR_W:0]     len_in;
  logic [DATA_W-1:0]   seed_eff;
  logic                last_xfer;
  logic                mismatch;
  logic                push;

  // Expected data and address travel with each read until its data returns.
  logic                vld_p [READ_LATENCY];
  logic [DATA_W-1:0]   exp_p [READ_LATENCY];
  logic [ADDR_W-1:0]   adr_p [READ_LATENCY];

  assign len_in    = clamp_len(length);
  // A zero LFSR state would lock up, so a zero seed is replaced by 1.
  assign seed_eff  = (pattern_mode && seed == '0) ? LFSR_ONE : seed;
  assign last_xfer = ((idx + 1'b1) == len_r);
  assign push      = avm_chipselect && !avm_write;
  assign mismatch  = vld_p[READ_LATENCY-1] && (avm_readdata != exp_p[READ_LATENCY-1]);

  always_comb begin
    state_d   = state;
    idx_d     = idx;
    pat_d     = pat;
    cs_d      = 1'b0;
    we_d      = 1'b0;
    addr_d    = '0;
    wdata_d   = '0;
    start_acc = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          idx_d     = '0;
          pat_d     = seed_eff;
          if (len_in == '0) begin
            state_d = DONE;
          end else begin
            state_d = WRITE;
            cs_d    = 1'b1;
            we_d    = 1'b1;
            addr_d  = base_addr;
            wdata_d = seed_eff;
          end
        end
      end
      WRITE: begin
        cs_d = 1'b1;
        if (last_xfer) begin
          // Re-seed so the read phase regenerates the written sequence.
          state_d = READ;
          idx_d   = '0;
          pat_d   = seed_r;
          addr_d  = base_r;
        end else begin
          idx_d   = idx + 1'b1;
          pat_d   = next_pat(pat, mode_r);
          we_d    = 1'b1;
          addr_d  = base_r + idx_d[ADDR_W-1:0];
          wdata_d = pat_d;
        end
      end
      READ: begin
        if (last_xfer) begin
          state_d = DRAIN;
          idx_d   = '0;
        end else begin
          cs_d   = 1'b1;
          idx_d  = idx + 1'b1;
          pat_d  = next_pat(pat, mode_r);
          addr_d = base_r + idx_d[ADDR_W-1:0];
        end
      end
      DRAIN: begin
        if (idx == RL_LAST) begin
          state_d = DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    err_d   = err_count;
    first_d = first_err_addr;
    found_d = err_found;
    if (start_acc) begin
      err_d   = '0;
      first_d = '0;
      found_d = 1'b0;
    end else if (mismatch) begin
      err_d = err_count + 1'b1;
      if (!err_found) begin
        first_d = adr_p[READ_LATENCY-1];
        found_d = 1'b1;
      end
    end

    // The verdict includes a mismatch detected on the edge that enters DONE.
    pass_d = pass;
    if (start_acc)        pass_d = 1'b0;
    if (state_d == DONE)  pass_d = (err_d == '0);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      idx            <= '0;
      len_r          <= '0;
      mode_r         <= 1'b0;
      err_found      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      avm_address    <= '0;
      avm_byteenable <= '0;
      avm_chipselect <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
      for (int k = 0; k < READ_LATENCY; k++) vld_p[k] <= 1'b0;
    end else begin
      state          <= state_d;
      idx            <= idx_d;
      err_found      <= found_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
      err_count      <= err_d;
      first_err_addr <= first_d;
      avm_address    <= addr_d;
      avm_byteenable <= {(DATA_W/8){cs_d}};
      avm_chipselect <= cs_d;
      avm_write      <= we_d;
      avm_writedata  <= wdata_d;
      if (start_acc) begin
        len_r  <= len_in;
        mode_r <= pattern_mode;
      end
      // Read-return pipeline: stage 0 loads when a read is on the bus.
      vld_p[0] <= push;
      for (int k = 1; k < READ_LATENCY; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (start_acc) begin
      base_r <= base_addr;
      seed_r <= seed_eff;
    end
    pat      <= pat_d;
    // Read-return pipeline data, aligned with vld_p.
    exp_p[0] <= pat;
    adr_p[0] <= avm_address;
    for (int k = 1; k < READ_LATENCY; k++) begin
      exp_p[k] <= exp_p[k-1];
      adr_p[k] <= adr_p[k-1];
    end
  end

endmodule
